alu_operand_sequencer: RTL and testbench
========================================

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, legal 1..15: clock edges allowed for the ripple adder to settle before SUM/carry_out are captured.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept a request.
REQ-006 SHALL have port op  input  2  00 ADD, 01 SUB, 10 ADC, 11 INC.
REQ-007 SHALL have ports operand_a and operand_b  input  4 each  unsigned/two's-complement operands.
REQ-008 SHALL have ports adder_bus0 and adder_bus1  output  4 each, and adder_carry_in  output  1: drive to the 4-bit adder's BUS0, BUS1 and carry_in.
REQ-009 SHALL have ports adder_sum  input  4 and adder_carry_out  input  1: taken from the adder's SUM and carry_out.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port result  output  4  captured sum.
REQ-013 SHALL have ports flag_c, flag_z, flag_v, flag_n  output  1 each: carry, zero, signed overflow, negative.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE and DONE.
REQ-016 In IDLE, in_ready SHALL be 1. On an edge with in_valid=1, the block SHALL latch op and operands into drive registers, load the counter with SETTLE_CYCLES-1 and go to SETTLE.
REQ-017 The adder inputs SHALL be driven from the drive registers as follows:
- ADD: bus0=a, bus1=b, cin=0.
- SUB: bus0=a, bus1=~b, cin=1.
- ADC: bus0=a, bus1=b, cin=current flag_c.
- INC: bus0=a, bus1=0, cin=1.
REQ-018 The drive registers SHALL remain unchanged from acceptance until the next acceptance.
REQ-019 In SETTLE, on each edge:
- counter≠0: decrement the counter.
- counter=0: capture result=adder_sum and update all four flags, then go to DONE.
- Consequence: out_valid rises exactly SETTLE_CYCLES edges after the accepting edge.
REQ-020 Flag rules, evaluated at capture:
- flag_c = adder_carry_out (for SUB, 1 means no borrow).
- flag_z = (adder_sum == 0).
- flag_n = adder_sum[3].
- flag_v = (bus0[3] == bus1[3]) AND (adder_sum[3] != bus0[3]).
REQ-021 In DONE, out_valid SHALL be 1. Result and flags SHALL be held stable until out_ready=1, then the FSM SHALL return to IDLE on that edge.
REQ-022 in_ready SHALL be 0 in SETTLE and DONE. in_valid in those states SHALL be ignored, with no queuing, so throughput is at most one operation per SETTLE_CYCLES+2 cycles.
REQ-023 result and flags SHALL change only at capture. They SHALL persist across IDLE so that ADC chains through the flag_c of the previous completed operation.
REQ-024 out_valid=1 with out_ready held 0 indefinitely SHALL keep the block in DONE with no change to any output.

Reset
REQ-025 While rst_n=0, regardless of the clock, the block SHALL immediately force:
- state=IDLE, counter=0;
- drive registers=0, so adder_bus0=0, adder_bus1=0, adder_carry_in=0;
- result=0, all flags=0;
- out_valid=0, busy=0, in_ready=1.
REQ-026 Reset asserted in SETTLE or DONE SHALL discard the pending operation with no result emitted. After release, the first operation SHALL see flag_c=0.

Verification
REQ-027 ADD a=0x7, b=0x9, SETTLE_CYCLES=1 -> out_valid one edge after accept; result=0x0, C=1, Z=1, V=0, N=0.
REQ-028 SUB a=0x3, b=0x5 -> adder_bus1=0xA, adder_carry_in=1; result=0xE, C=0, Z=0, V=0, N=1.
REQ-029 ADD a=0x7, b=0x1 -> result=0x8, V=1, N=1, C=0. Then INC a=0xF -> result=0x0, C=1, Z=1.
REQ-030 ADD 0xF+0x1 (C=1), then ADC a=0x2, b=0x3 -> adder_carry_in=1, result=0x6, C=0.
REQ-031 SETTLE_CYCLES=4 with out_ready=0 for 5 cycles in DONE, new in_valid pulses during SETTLE/DONE -> out_valid 4 edges after accept; result/flags stable; in_ready=0; extra requests dropped.
REQ-032 rst_n pulsed low mid-SETTLE -> outputs zero asynchronously; no out_valid for the aborted operation; next ADC uses cin=0.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for an external 4-bit ripple adder: latches a request, drives the
// adder, waits SETTLE_CYCLES edges, then captures the sum and flags until the consumer accepts.
module alu_operand_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  logic [3:0] operand_a,
  input  logic [3:0] operand_b,
  output logic [3:0] adder_bus0,
  output logic [3:0] adder_bus1,
  output logic       adder_carry_in,
  input  logic [3:0] adder_sum,
  input  logic       adder_carry_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] result,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_v,
  output logic       flag_n,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [1:0] op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       ovf;

  // Adder inputs come only from the drive registers, so they stay frozen while it settles.
  // ADC reads the live flag_c, which cannot change before this operation's own capture.
  always_comb begin
    adder_bus0     = a_q;
    adder_bus1     = b_q;
    adder_carry_in = 1'b0;
    case (op_q)
      OP_ADD: begin
        adder_bus1     = b_q;
        adder_carry_in = 1'b0;
      end
      OP_SUB: begin
        adder_bus1     = ~b_q;
        adder_carry_in = 1'b1;
      end
      OP_ADC: begin
        adder_bus1     = b_q;
        adder_carry_in = flag_c;
      end
      OP_INC: begin
        adder_bus1     = 4'd0;
        adder_carry_in = 1'b1;
      end
      default: begin
        adder_bus1     = b_q;
        adder_carry_in = 1'b0;
      end
    endcase
  end

  assign ovf = (adder_bus0[3] == adder_bus1[3]) && (adder_sum[3] != adder_bus0[3]);

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      op_q   <= 2'd0;
      a_q    <= 4'd0;
      b_q    <= 4'd0;
      result <= 4'd0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= op;
            a_q   <= operand_a;
            b_q   <= operand_b;
            cnt   <= CNT_LOAD;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            result <= adder_sum;
            flag_c <= adder_carry_out;
            flag_z <= (adder_sum == 4'd0);
            flag_v <= ovf;
            flag_n <= adder_sum[3];
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: two sequencers (settle 1 and 4), each wired to a behavioural 4-bit adder.
module tb_alu_operand_sequencer;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, INC = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] op = 2'd0;
  logic [3:0] opa = 4'd0, opb = 4'd0;

  logic iv1 = 1'b0, or1 = 1'b0;
  logic ir1, ov1, cin1, co1, c1, z1, v1, n1, busy1;
  logic [3:0] b0_1, b1_1, sum1, res1;

  logic iv4 = 1'b0, or4 = 1'b0;
  logic ir4, ov4, cin4, co4, c4, z4, v4, n4, busy4;
  logic [3:0] b0_4, b1_4, sum4, res4;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign {co1, sum1} = {1'b0, b0_1} + {1'b0, b1_1} + {4'd0, cin1};
  assign {co4, sum4} = {1'b0, b0_4} + {1'b0, b1_4} + {4'd0, cin4};

  alu_operand_sequencer #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op),
    .operand_a(opa), .operand_b(opb), .adder_bus0(b0_1), .adder_bus1(b1_1),
    .adder_carry_in(cin1), .adder_sum(sum1), .adder_carry_out(co1),
    .out_valid(ov1), .out_ready(or1), .result(res1),
    .flag_c(c1), .flag_z(z1), .flag_v(v1), .flag_n(n1), .busy(busy1));

  alu_operand_sequencer #(.SETTLE_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op(op),
    .operand_a(opa), .operand_b(opb), .adder_bus0(b0_4), .adder_bus1(b1_4),
    .adder_carry_in(cin4), .adder_sum(sum4), .adder_carry_out(co4),
    .out_valid(ov4), .out_ready(or4), .result(res4),
    .flag_c(c4), .flag_z(z4), .flag_v(v4), .flag_n(n4), .busy(busy4));

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] bus1;
    logic       cin;
    logic [3:0] res;
    logic [3:0] czvn;
  } vec_t;

  vec_t tv[9];

  // One full transaction on the settle-1 instance, starting and ending in IDLE.
  task automatic run1(input vec_t v, input int idx);
    check($sformatf("v%0d in_ready idle", idx), ir1, 1);
    op = v.op; opa = v.a; opb = v.b; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    check($sformatf("v%0d out_valid settle", idx), ov1, 0);
    check($sformatf("v%0d in_ready settle", idx), ir1, 0);
    check($sformatf("v%0d bus0", idx), b0_1, v.a);
    check($sformatf("v%0d bus1", idx), b1_1, v.bus1);
    check($sformatf("v%0d cin", idx), cin1, v.cin);
    tick();
    check($sformatf("v%0d out_valid done", idx), ov1, 1);
    check($sformatf("v%0d result", idx), res1, v.res);
    check($sformatf("v%0d czvn", idx), {c1, z1, v1, n1}, v.czvn);
    or1 = 1'b1;
    tick();
    or1 = 1'b0;
    check($sformatf("v%0d out_valid after accept", idx), ov1, 0);
  endtask

  // Full transaction on the settle-4 instance.
  task automatic run4(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                      input logic ecin, input logic [3:0] eres, input logic [3:0] eczvn,
                      input string nm);
    op = o; opa = a; opb = b; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    check({nm, " cin"}, cin4, ecin);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s out_valid early %0d", nm, k), ov4, 0);
      tick();
    end
    check({nm, " out_valid"}, ov4, 1);
    check({nm, " result"}, res4, eres);
    check({nm, " czvn"}, {c4, z4, v4, n4}, eczvn);
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
  endtask

  initial begin
    tv[0] = '{ADD, 4'h7, 4'h9, 4'h9, 1'b0, 4'h0, 4'b1100};
    tv[1] = '{SUB, 4'h3, 4'h5, 4'hA, 1'b1, 4'hE, 4'b0001};
    tv[2] = '{ADD, 4'h7, 4'h1, 4'h1, 1'b0, 4'h8, 4'b0011};
    tv[3] = '{INC, 4'hF, 4'h6, 4'h0, 1'b1, 4'h0, 4'b1100};
    tv[4] = '{ADD, 4'hF, 4'h1, 4'h1, 1'b0, 4'h0, 4'b1100};
    tv[5] = '{ADC, 4'h2, 4'h3, 4'h3, 1'b1, 4'h6, 4'b0000};
    tv[6] = '{ADC, 4'h2, 4'h3, 4'h3, 1'b0, 4'h5, 4'b0000};
    tv[7] = '{SUB, 4'h8, 4'h1, 4'hE, 1'b1, 4'h7, 4'b1010};
    tv[8] = '{SUB, 4'h5, 4'h5, 4'hA, 1'b1, 4'h0, 4'b1100};

    // Reset values before any clock edge
    #3;
    check("rst in_ready", ir1, 1);
    check("rst out_valid", ov1, 0);
    check("rst busy", busy1, 0);
    check("rst bus", {b0_1, b1_1, cin1}, 0);
    check("rst result/flags", {res1, c1, z1, v1, n1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run1(tv[i], i);

    // Settle-4: latency, held DONE with out_ready low, dropped requests
    op = ADD; opa = 4'h7; opb = 4'h1; iv4 = 1'b1;
    tick();
    op = SUB; opa = 4'h0; opb = 4'h3;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s4 out_valid early %0d", k), ov4, 0);
      check($sformatf("s4 in_ready settle %0d", k), ir4, 0);
      check($sformatf("s4 bus0 frozen %0d", k), b0_4, 4'h7);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("s4 out_valid held %0d", k), ov4, 1);
      check($sformatf("s4 result held %0d", k), res4, 4'h8);
      check($sformatf("s4 czvn held %0d", k), {c4, z4, v4, n4}, 4'b0011);
      check($sformatf("s4 in_ready done %0d", k), ir4, 0);
      check($sformatf("s4 bus frozen %0d", k), {b0_4, b1_4, cin4}, {4'h7, 4'h1, 1'b0});
      tick();
    end
    iv4 = 1'b0; or4 = 1'b1;
    tick();
    or4 = 1'b0;
    check("s4 out_valid released", ov4, 0);
    check("s4 in_ready released", ir4, 1);
    tick();
    check("s4 no queued op", busy4, 0);

    // Reset mid-SETTLE discards the ADC and clears flag_c
    run4(ADD, 4'hF, 4'h1, 1'b0, 4'h0, 4'b1100, "pre-rst add");
    op = ADC; opa = 4'h2; opb = 4'h3; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    check("abort adc cin", cin4, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", busy4, 0);
    check("async rst in_ready", ir4, 1);
    check("async rst bus", {b0_4, b1_4, cin4}, 0);
    check("async rst result/flags", {res4, c4, z4, v4, n4}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("aborted no out_valid %0d", k), ov4, 0);
    end
    run4(ADC, 4'h2, 4'h3, 1'b0, 4'h5, 4'b0000, "post-rst adc");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
